// File: rtl/vr_fifo.sv
// vr_fifo: valid/ready FIFO absorbing rate mismatch between a source and a sink
// ports: clk, reset (sync, active-high); s_valid/s_ready/s_data upstream;
//        m_valid/m_ready/m_data downstream; count = occupancy 0..DEPTH
module vr_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]  count
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic in_reset, push, pop;
   // in_reset keeps s_ready low through the first posedge after reset release
   assign s_ready = (count != CNT_W'(DEPTH)) && !in_reset;
   assign m_valid = count != '0;
   assign m_data = mem[rd_ptr];
   assign push = s_valid && s_ready;
   assign pop = m_valid && m_ready;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         in_reset <= 1'b1;
      end else begin
         in_reset <= 1'b0;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end
   // storage is deliberately unreset; a write during reset is harmless as pointers clear
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= s_data;
endmodule

// File: tb/tb_vr_fifo.sv
// tb_vr_fifo: queue-model and directed checks for vr_fifo
module tb_vr_fifo;
   localparam int DW = 8, DEPTH = 4, CW = $clog2(DEPTH) + 1;
   logic clk = 0, reset = 1, s_valid = 0, m_ready = 0;
   logic [DW-1:0] s_data = '0;
   logic s_ready, m_valid;
   logic [DW-1:0] m_data;
   logic [CW-1:0] count;
   int checks = 0, errors = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] sink_q[$];
   bit mir = 1, started = 0;

   vr_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // behavioural model: a bounded queue, accepting only when not full and not just out of reset
   always @(posedge clk) begin
      automatic bit do_push = s_valid && !mir && q.size() < DEPTH;
      automatic bit do_pop = m_ready && q.size() > 0;
      started <= 1;
      if (reset) begin
         q.delete();
         mir = 1;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(s_data);
         mir = 0;
      end
   end

   // compare process plus sink capture; inputs are stable from #1 after posedge to the next posedge
   always @(negedge clk) if (started) begin
      chk("s_ready", s_ready, !mir && q.size() < DEPTH);
      chk("m_valid", m_valid, q.size() > 0);
      chk("count", count, q.size());
      if (q.size() > 0) chk("m_data", m_data, q[0]);
      if (m_valid && m_ready && !reset) sink_q.push_back(m_data);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned seed_dummy;
      bit ok;
      int guard;
      step();
      step();
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_count", count, 0);
      reset = 0;
      @(negedge clk);
      chk("rel_s_ready", s_ready, 1);
      chk("rel_m_valid", m_valid, 0);
      // single beat
      s_valid = 1; s_data = 8'hA5; m_ready = 1;
      step();
      s_valid = 0;
      @(negedge clk);
      chk("one_m_valid", m_valid, 1);
      chk("one_m_data", m_data, 8'hA5);
      step();
      @(negedge clk);
      chk("one_count", count, 0);
      // fill to full with 0x05 held off
      m_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         s_valid = 1; s_data = DW'(i);
         step();
      end
      @(negedge clk);
      chk("full_count", count, 4);
      chk("full_s_ready", s_ready, 0);
      chk("full_head", m_data, 8'h01);
      m_ready = 1;
      step();
      m_ready = 0;
      @(negedge clk);
      chk("pop1_count", count, 3);
      chk("pop1_s_ready", s_ready, 1);
      chk("pop1_head", m_data, 8'h02);
      step();
      s_valid = 0;
      @(negedge clk);
      chk("refill_count", count, 4);
      sink_q.delete();
      m_ready = 1;
      repeat (5) step();
      chk("drain_len", sink_q.size(), 4);
      if (sink_q.size() == 4) chk("drain_last", sink_q[3], 8'h05);
      // simultaneous push+pop at count 2, then wrap
      sink_q.delete();
      m_ready = 0; s_valid = 1;
      s_data = 8'h10; step();
      s_data = 8'h11; step();
      m_ready = 1; s_data = 8'h12; step();
      @(negedge clk);
      chk("pp_count", count, 2);
      chk("pp_head", m_data, 8'h11);
      s_data = 8'h13; step();
      for (int i = 0; i < 12; i++) begin
         s_data = DW'(8'h20 + i);
         step();
      end
      @(negedge clk);
      chk("wrap_count", count, 2);
      s_valid = 0;
      repeat (3) step();
      chk("wrap_len", sink_q.size(), 16);
      for (int i = 0; i < 16 && i < sink_q.size(); i++)
         chk("wrap_beat", sink_q[i], i < 4 ? 8'h10 + i : 8'h20 + i - 4);
      // random stall soak
      sink_q.delete();
      m_ready = 0;
      seed_dummy = $urandom(17);
      fork
         begin
            for (int i = 0; i < 120; i++) begin
               s_valid = 0;
               repeat ($urandom_range(5, 0)) step();
               s_valid = 1; s_data = DW'(i);
               guard = 0;
               do begin
                  ok = s_ready;
                  step();
                  guard++;
               end while (!ok && guard < 1000);
               if (!ok) chk("src_stall", guard, 0);
            end
            s_valid = 0;
         end
         begin
            int g2;
            bit ok2;
            for (int i = 0; i < 120; i++) begin
               m_ready = 0;
               repeat ($urandom_range(5, 0)) step();
               m_ready = 1;
               g2 = 0;
               do begin
                  ok2 = m_valid;
                  step();
                  g2++;
               end while (!ok2 && g2 < 1000);
               if (!ok2) chk("sink_stall", g2, 0);
            end
            m_ready = 0;
         end
      join
      chk("soak_len", sink_q.size(), 120);
      for (int i = 0; i < 120 && i < sink_q.size(); i++) chk("soak_beat", sink_q[i], DW'(i));
      // reset mid-stream
      s_valid = 1;
      for (int i = 0; i < 3; i++) begin
         s_data = DW'(8'h50 + i);
         step();
      end
      s_data = 8'h77;
      @(negedge clk);
      chk("mid_count", count, 3);
      reset = 1;
      step();
      @(negedge clk);
      chk("mid_m_valid", m_valid, 0);
      chk("mid_rst_count", count, 0);
      reset = 0; s_valid = 0;
      step();
      @(negedge clk);
      chk("mid_s_ready", s_ready, 1);
      sink_q.delete();
      s_valid = 1; s_data = 8'h3C; m_ready = 1;
      step();
      s_valid = 0;
      step();
      step();
      chk("mid_len", sink_q.size(), 1);
      if (sink_q.size() > 0) chk("mid_first", sink_q[0], 8'h3C);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vr_fifo.md
# vr_fifo

Synchronous valid/ready FIFO with a slave port on the upstream side and a master port on the downstream side. It sits between a source and a sink on the valid_ready bus to absorb rate mismatch. It decouples the source's random production delay from the sink's random consumption delay without losing, duplicating or reordering beats. It owns the ready output of the upstream link and the valid output of the downstream link, so it completes the protocol in both directions.

## Interface

Parameters:
- DATA_W, 8, payload width in bits
- DEPTH, 4, number of storage entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- s_valid  in  1  upstream beat offered
- s_ready  out  1  FIFO can accept a beat this cycle
- s_data  in  DATA_W  upstream payload
- m_valid  out  1  FIFO holds a beat for downstream
- m_ready  in  1  downstream accepts the beat
- m_data  out  DATA_W  payload at head of FIFO
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation

- Push: s_valid && s_ready at posedge. The beat is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop: m_valid && m_ready at posedge. rd_ptr advances modulo DEPTH.
- Derived flags:
  - s_ready = (count != DEPTH) && !in_reset.
  - m_valid = (count != 0).
  - in_reset is a flop set by reset and cleared on the first posedge with reset low.
- m_data = mem[rd_ptr], driven combinationally from storage. It is stable while m_valid && !m_ready.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push+pop, or when neither occurs.
- Pointer width is $clog2(DEPTH). Wrap is natural binary overflow. Full/empty are decided by count, not by pointer comparison.
- Order is preserved: beat N popped equals beat N pushed.
- Full, with pop this cycle: s_ready is 0, so no push occurs. s_ready rises next cycle (no same-cycle pass-through).
- Empty, with push this cycle: no bypass. m_valid rises next cycle with the pushed data.
- Once asserted, m_valid stays high with m_data unchanged until m_ready is sampled high. The same holds for the source's s_valid/s_data; the FIFO does not check this.
- Storage contents are not reset. Only pointers, count and in_reset are reset.

## Timing

- Reset values, held while reset is high and at the first posedge after release:
  - s_ready = 0, m_valid = 0, count = 0, wr_ptr = rd_ptr = 0.
  - m_data is don't-care.
- s_ready = 1 from the first cycle after the first posedge with reset low.
- Latency from push to m_valid: 1 clock. Back-to-back throughput: 1 beat/clock when neither side stalls.
- Reset mid-operation: all queued beats are discarded. Pointers and count are 0 on the next posedge, and m_valid drops on that same posedge.
- s_ready and m_valid are functions of registered state only. There is no combinational path from s_valid or m_ready to any output.

## Test plan

- Reset release: hold reset 2 cycles, then deassert → s_ready=0, m_valid=0, count=0 during reset; s_ready=1 one cycle later, m_valid stays 0.
- Single beat: push 0xA5 with m_ready=1 → m_valid=1, m_data=0xA5 on the next cycle; popped that cycle; count returns to 0.
- Fill to full: DEPTH=4, m_ready=0, push 0x01..0x05 on consecutive cycles → 0x01..0x04 accepted; count=4; s_ready=0; 0x05 held off. Then m_ready=1 for 1 cycle → 0x01 popped, s_ready=1 next cycle, 0x05 accepted.
- Simultaneous push+pop at count=2 → count stays 2, order preserved. Across ≥ 3·DEPTH beats, pointers wrap with no corruption.
- Random stall soak: source delay and sink delay each drawn from $urandom_range(5,0) per handshake, seed 17, 100+ beats of an incrementing pattern → scoreboard sees an exact in-order match, count never exceeds 4, no push while s_ready=0.
- Reset mid-stream: count=3, assert reset for 1 cycle → m_valid=0 and count=0 at that posedge. The next pushed 0x3C is the first beat popped.
